hazard_forward_unit: RTL and testbench

Forwarding and load-use hazard controller for the 5-stage MIPS pipeline; it drives the select lines of the 32-bit operand muxes in EX and the stall controls of IF/ID. It tracks the destination register of every in-flight instruction in its own EX/MEM/WB shadow pipeline. Each cycle it registers forwarding selects for the instruction leaving ID, and it raises a one-cycle stall when a load is followed by a dependent instruction.

---
 rtl/mips_hazard_pkg.sv | 42 ++++
 rtl/hazard_stage_reg.sv | 25 ++
 rtl/hazard_forward_unit.sv | 116 +++++++++++
 tb/tb_hazard_forward_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_hazard_pkg.sv
// Shared types and constants for the MIPS forwarding/hazard unit.
//   fwd_sel_e      : EX operand mux source encoding
//   shadow_entry_t : one in-flight instruction's writeback footprint
//   fwd_match      : does a shadow entry supply a given source operand
//   fwd_pick       : forwarding select for one operand
package mips_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic [4:0] dest;
  } shadow_entry_t;

  // An entry supplies an operand only when it really writes a nonzero
  // register and the consumer really reads that operand.
  function automatic logic fwd_match(input shadow_entry_t e,
                                     input logic          uses,
                                     input logic [4:0]    src);
    return e.valid & e.reg_write & (e.dest != REG_ZERO) & uses & (e.dest == src);
  endfunction

  // The EX entry is about to become MEM; the MEM entry is about to become WB.
  // A load in EX cannot supply its data from MEM; the load-use stall covers it.
  function automatic fwd_sel_e fwd_pick(input shadow_entry_t ex,
                                        input shadow_entry_t mem,
                                        input logic          uses,
                                        input logic [4:0]    src);
    if (fwd_match(ex, uses, src) && !ex.mem_read) return FWD_MEM;
    if (fwd_match(mem, uses, src))                return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline entry (EX, MEM or WB).
//   clk, rst_n : clock, async active-low reset (entry cleared)
//   bubble     : load an all-zero entry instead of d
//   d / q      : next / current entry
module hazard_stage_reg
  import mips_hazard_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bubble,
  input  shadow_entry_t d,
  output shadow_entry_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
//   clk, rst_n            : clock, async active-low reset
//   id_*                  : decoded fields of the instruction in ID
//   flush                 : taken branch/jump squashes the ID instruction
//   fwd_a_sel, fwd_b_sel  : registered EX operand mux selects
//   stall                 : load-use hazard (combinational)
//   pc_write, ifid_write  : front-end write enables (~stall)
//   bubble                : ID/EX loads a NOP this cycle
//   stall_count           : saturating count of stall cycles
module hazard_forward_unit
  import mips_hazard_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [4:0]             id_dest,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   flush,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic                   stall,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   bubble,
  output logic [STALL_CNT_W-1:0] stall_count
);

  shadow_entry_t id_entry, ex_q, mem_q, wb_q;
  logic          ex_bubble;
  fwd_sel_e      fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;
  logic [STALL_CNT_W-1:0] stall_count_q;

  assign id_entry = '{valid: 1'b1, reg_write: id_reg_write,
                      mem_read: id_mem_read, dest: id_dest};

  // Stall/RUN state lives in the EX entry: the stall inserts a bubble into
  // EX, so the following cycle can never match again for the same load.
  always_comb begin
    stall = 1'b0;
    if (id_valid && !flush && ex_q.mem_read) begin
      stall = fwd_match(ex_q, id_uses_rs, id_rs) | fwd_match(ex_q, id_uses_rt, id_rt);
    end
  end

  assign bubble     = stall | flush;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;
  assign ex_bubble  = bubble | ~id_valid;

  hazard_stage_reg u_ex (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (ex_bubble),
    .d      (id_entry),
    .q      (ex_q)
  );

  hazard_stage_reg u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  hazard_stage_reg u_wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  // The WB entry retires here; nothing downstream of it is forwarded.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  always_comb begin
    fwd_a_d = FWD_REG;
    fwd_b_d = FWD_REG;
    if (!bubble) begin
      fwd_a_d = fwd_pick(ex_q, mem_q, id_uses_rs, id_rs);
      fwd_b_d = fwd_pick(ex_q, mem_q, id_uses_rt, id_rt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (stall && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + STALL_CNT_W'(1);
    end
  end

  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding selects, load-use stall,
// flush priority, $0 handling, async reset mid-stall and counter saturation.
module tb_hazard_forward_unit;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [4:0]    id_rs, id_rt, id_dest;
  logic          id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic          flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall, pc_write, ifid_write, bubble;
  logic [CW-1:0] stall_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.STALL_CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .bubble       (bubble),
    .stall_count  (stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_rs        = '0;
    id_rt        = '0;
    id_uses_rs   = 1'b0;
    id_uses_rt   = 1'b0;
    id_dest      = '0;
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
  endtask

  task automatic put(input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt,
                     input logic [4:0] dest, input logic rw, input logic mr);
    id_valid     = 1'b1;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_dest      = dest;
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    idle();
    #3;
    chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bubble", 32'(bubble), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_ifid_write", 32'(ifid_write), 32'd1);
    chk("rst_count", 32'(stall_count), 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // add $3 ; sub reads $3 as rs -> MEM forward on A
    put(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    put(5'd3, 5'd4, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1 chk("alu_b2b_stall", 32'(stall), 32'd0);
    tick();
    chk("alu_b2b_fwd_a", 32'(fwd_a_sel), 32'd2);
    chk("alu_b2b_fwd_b", 32'(fwd_b_sel), 32'd0);

    // producer $8, independent op, consumer reads $8 as rt -> WB forward on B
    put(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    put(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    put(5'd1, 5'd8, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    chk("gap1_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("gap1_fwd_b", 32'(fwd_b_sel), 32'd1);

    // lw $5 ; add reads $5 -> one stall cycle, then WB forward
    put(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    put(5'd5, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_ifid_write", 32'(ifid_write), 32'd0);
    chk("lu_bubble", 32'(bubble), 32'd1);
    tick();
    chk("lu_stall_gone", 32'(stall), 32'd0);
    chk("lu_bubble_gone", 32'(bubble), 32'd0);
    chk("lu_pc_write_back", 32'(pc_write), 32'd1);
    chk("lu_bubble_sel", 32'(fwd_a_sel), 32'd0);
    chk("lu_count", 32'(stall_count), 32'd1);
    tick();
    chk("lu_fwd_a", 32'(fwd_a_sel), 32'd1);
    chk("lu_fwd_b", 32'(fwd_b_sel), 32'd0);
    chk("lu_count_hold", 32'(stall_count), 32'd1);

    // lw $0 ; consumer reads $0 -> no stall, no forward
    put(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1);
    tick();
    put(5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    #1 chk("r0_stall", 32'(stall), 32'd0);
    tick();
    chk("r0_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("r0_fwd_b", 32'(fwd_b_sel), 32'd0);

    // two writers of $7 back to back -> newest (MEM) wins; unused rt ignored
    put(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    put(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    put(5'd7, 5'd7, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0);
    tick();
    chk("dual_fwd_a", 32'(fwd_a_sel), 32'd2);
    chk("dual_unused_rt", 32'(fwd_b_sel), 32'd0);

    // flush on a load-use match: no stall, bubble into EX
    put(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    tick();
    put(5'd5, 5'd2, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stall), 32'd0);
    chk("fl_bubble", 32'(bubble), 32'd1);
    chk("fl_pc_write", 32'(pc_write), 32'd1);
    tick();
    flush = 1'b0;
    put(5'd13, 5'd5, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);
    #1 chk("fl_no_stall_after", 32'(stall), 32'd0);
    tick();
    chk("fl_ex_bubble_a", 32'(fwd_a_sel), 32'd0);
    chk("fl_load_wb_b", 32'(fwd_b_sel), 32'd1);
    chk("fl_count", 32'(stall_count), 32'd1);

    // reset asserted during a stall
    put(5'd15, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    chk("pre_rst_fwd_a", 32'(fwd_a_sel), 32'd2);
    put(5'd5, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    #1 chk("pre_rst_stall", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_bubble", 32'(bubble), 32'd0);
    chk("mid_rst_pc_write", 32'(pc_write), 32'd1);
    chk("mid_rst_ifid_write", 32'(ifid_write), 32'd1);
    chk("mid_rst_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("mid_rst_fwd_b", 32'(fwd_b_sel), 32'd0);
    chk("mid_rst_count", 32'(stall_count), 32'd0);
    idle();
    #2 rst_n = 1'b1;
    tick();

    // repeated load-use stalls: counter saturates at all-ones
    for (int k = 1; k <= 4; k++) begin
      put(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      put(5'd5, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
      #1 chk("sat_stall", 32'(stall), 32'd1);
      tick();
      chk("sat_single_cycle", 32'(stall), 32'd0);
      tick();
      chk("sat_count", 32'(stall_count), (k < 3) ? 32'(k) : 32'd3);
    end

    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
